// File: rtl/drac_pkg.sv
// Shared types for the dcache request tracker: entry lifecycle states,
// the per-entry request record and the memory command encodings.
package drac_pkg;

   typedef logic [63:0] bus_simd_t;

   typedef enum logic [1:0] {
      ST_FREE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ISSUED  = 2'd2,
      ST_KILLED  = 2'd3
   } entry_state_e;

   typedef struct packed {
      logic [4:0]  cmd;
      logic [3:0]  size;
      logic [39:0] addr;
      bus_simd_t   data;
      logic [4:0]  rd;
   } entry_t;

   localparam logic [4:0] M_XRD     = 5'b00000;
   localparam logic [4:0] M_XWR     = 5'b00001;
   localparam logic [4:0] M_PFR     = 5'b00010;
   localparam logic [4:0] M_PFW     = 5'b00011;
   localparam logic [4:0] M_XA_SWAP = 5'b00100;

endpackage

// File: rtl/dcache_req_age_matrix.sv
// Allocation-order matrix: older_q[i][j] means entry i was allocated before j.
// Picks the oldest entry among those flagged pending.
module dcache_req_age_matrix #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             alloc_i,
   input  logic [IDX_W-1:0] alloc_idx_i,
   input  logic [N-1:0]     pend_i,
   output logic             oldest_valid_o,
   output logic [IDX_W-1:0] oldest_idx_o
);

   logic [N-1:0][N-1:0] older_q, older_d;
   logic [N-1:0]        is_oldest;

   // A new entry is younger than every other; its own row is cleared so
   // relations left over from a previous occupant of the slot disappear.
   always_comb begin
      older_d = older_q;
      if (alloc_i) begin
         for (int j = 0; j < N; j++) begin
            older_d[alloc_idx_i][j] = 1'b0;
            older_d[j][alloc_idx_i] = (j != int'(alloc_idx_i));
         end
      end
   end

   always_comb begin
      is_oldest      = pend_i;
      oldest_valid_o = 1'b0;
      oldest_idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (pend_i[j] && older_q[j][i]) is_oldest[i] = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (is_oldest[i] && !oldest_valid_o) begin
            oldest_valid_o = 1'b1;
            oldest_idx_o   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) older_q <= '0;
      else       older_q <= older_d;
   end

endmodule

// File: rtl/dcache_req_tracker.sv
// Tracks outstanding CPU memory requests: buffers them, issues the oldest
// pending one to the dcache, handles nack replay, kill and out-of-order responses.
module dcache_req_tracker
   import drac_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [4:0]                     req_cmd_i,
   input  logic [3:0]                     req_size_i,
   input  logic [39:0]                    req_addr_i,
   input  bus_simd_t                      req_data_i,
   input  logic [4:0]                     req_rd_i,
   input  logic                           kill_i,
   output logic                           dmem_req_valid_o,
   input  logic                           dmem_req_ready_i,
   output logic [4:0]                     dmem_req_cmd_o,
   output logic [39:0]                    dmem_req_addr_o,
   output logic [3:0]                     dmem_op_type_o,
   output bus_simd_t                      dmem_req_data_o,
   output logic [TAG_W-1:0]               dmem_req_tag_o,
   input  logic                           dmem_resp_valid_i,
   input  logic                           dmem_resp_nack_i,
   input  logic [TAG_W-1:0]               dmem_resp_tag_i,
   input  bus_simd_t                      dmem_resp_data_i,
   output logic                           resp_valid_o,
   output logic [4:0]                     resp_rd_o,
   output bus_simd_t                      resp_data_o,
   output logic [$clog2(NUM_ENTRIES):0]   outstanding_o
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   entry_state_e     st_q  [NUM_ENTRIES];
   entry_state_e     st_d  [NUM_ENTRIES];
   entry_t           ent_q [NUM_ENTRIES];
   entry_t           ent_d [NUM_ENTRIES];
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             resp_valid_q, resp_valid_d;
   logic [4:0]       resp_rd_q, resp_rd_d;
   bus_simd_t        resp_data_q, resp_data_d;

   logic                   free_any;
   logic [IDX_W-1:0]       alloc_idx;
   logic [NUM_ENTRIES-1:0] pend_mask;
   logic [CNT_W-1:0]       busy_cnt;
   logic                   oldest_valid;
   logic [IDX_W-1:0]       oldest_idx;
   logic [IDX_W-1:0]       pres_idx;
   logic [IDX_W-1:0]       resp_idx;
   logic                   alloc, issue, resp_hit;
   entry_t                 pres_ent;

   // Output decode from registered entry states; descending scan yields lowest free.
   always_comb begin
      free_any  = 1'b0;
      alloc_idx = '0;
      pend_mask = '0;
      busy_cnt  = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (st_q[i] == ST_FREE) begin
            free_any  = 1'b1;
            alloc_idx = IDX_W'(i);
         end else begin
            busy_cnt = busy_cnt + CNT_W'(1);
         end
         pend_mask[i] = (st_q[i] == ST_PENDING);
      end
   end

   // Handshakes are valid/ready: a transfer happens in any cycle where both are high.
   // A stalled dcache request stays locked to its entry so the outputs hold steady.
   assign req_ready_o      = free_any && !kill_i;
   assign alloc            = req_valid_i && req_ready_o;
   assign pres_idx         = lock_q ? lock_idx_q : oldest_idx;
   assign dmem_req_valid_o = lock_q || oldest_valid;
   assign issue            = dmem_req_valid_o && dmem_req_ready_i;
   assign pres_ent         = dmem_req_valid_o ? ent_q[pres_idx] : '0;
   assign dmem_req_cmd_o   = pres_ent.cmd;
   assign dmem_req_addr_o  = pres_ent.addr;
   assign dmem_op_type_o   = pres_ent.size;
   assign dmem_req_data_o  = pres_ent.data;
   assign dmem_req_tag_o   = dmem_req_valid_o ? TAG_W'(pres_idx) : '0;
   assign outstanding_o    = busy_cnt;
   assign resp_hit         = dmem_resp_valid_i && (dmem_resp_tag_i < TAG_W'(NUM_ENTRIES));
   assign resp_idx         = dmem_resp_tag_i[IDX_W-1:0];
   assign resp_valid_o     = resp_valid_q;
   assign resp_rd_o        = resp_rd_q;
   assign resp_data_o      = resp_data_q;

   dcache_req_age_matrix #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_age (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .alloc_i        (alloc),
      .alloc_idx_i    (alloc_idx),
      .pend_i         (pend_mask),
      .oldest_valid_o (oldest_valid),
      .oldest_idx_o   (oldest_idx)
   );

   // Next state: handshakes land first, then a kill rewrites the result.
   always_comb begin
      st_d  = st_q;
      ent_d = ent_q;
      if (alloc) begin
         st_d[alloc_idx]  = ST_PENDING;
         ent_d[alloc_idx] = '{cmd: req_cmd_i, size: req_size_i, addr: req_addr_i,
                              data: req_data_i, rd: req_rd_i};
      end
      if (issue) st_d[pres_idx] = ST_ISSUED;
      if (resp_hit) begin
         case (st_q[resp_idx])
            ST_ISSUED: st_d[resp_idx] = dmem_resp_nack_i ? ST_PENDING : ST_FREE;
            ST_KILLED: st_d[resp_idx] = ST_FREE;
            default:   ;
         endcase
      end
      if (kill_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (st_d[i] == ST_PENDING)     st_d[i] = ST_FREE;
            else if (st_d[i] == ST_ISSUED) st_d[i] = ST_KILLED;
         end
      end
      resp_valid_d = resp_hit && !dmem_resp_nack_i && !kill_i &&
                     (st_q[resp_idx] == ST_ISSUED);
      resp_rd_d    = resp_valid_d ? ent_q[resp_idx].rd : resp_rd_q;
      resp_data_d  = resp_valid_d ? dmem_resp_data_i : resp_data_q;
      lock_d       = dmem_req_valid_o && !dmem_req_ready_i && !kill_i;
      lock_idx_d   = pres_idx;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            st_q[i]  <= ST_FREE;
            ent_q[i] <= '0;
         end
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_rd_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         st_q         <= st_d;
         ent_q        <= ent_d;
         lock_q       <= lock_d;
         lock_idx_q   <= lock_idx_d;
         resp_valid_q <= resp_valid_d;
         resp_rd_q    <= resp_rd_d;
         resp_data_q  <= resp_data_d;
      end
   end

endmodule

// File: tb/tb_dcache_req_tracker.sv
// Bench for dcache_req_tracker: directed scenarios plus random traffic, all
// checked every cycle against an age-queue reference model.
module tb_dcache_req_tracker;
   import drac_pkg::*;

   localparam int N      = 4;
   localparam int TAG_W  = 8;
   localparam int S_FREE = 0;
   localparam int S_PEND = 1;
   localparam int S_ISS  = 2;
   localparam int S_KIL  = 3;
   localparam int W      = 69;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [4:0]       req_cmd, req_rd;
   logic [3:0]       req_size;
   logic [39:0]      req_addr;
   bus_simd_t        req_data;
   logic             kill;
   logic             dmem_valid, dmem_ready;
   logic [4:0]       dmem_cmd;
   logic [39:0]      dmem_addr;
   logic [3:0]       dmem_op;
   bus_simd_t        dmem_data;
   logic [TAG_W-1:0] dmem_tag;
   logic             resp_valid_in, resp_nack;
   logic [TAG_W-1:0] resp_tag;
   bus_simd_t        resp_data_in;
   logic             resp_valid;
   logic [4:0]       resp_rd;
   bus_simd_t        resp_data;
   logic [2:0]       outstanding;

   int checks   = 0;
   int failures = 0;

   // Reference model: per-tag lifecycle plus allocation order as a queue.
   int          st_m [N];
   logic [4:0]  rd_m [N];
   logic [4:0]  cmd_m [N];
   logic [3:0]  size_m [N];
   logic [39:0] addr_m [N];
   bus_simd_t   data_m [N];
   int          age_q [$];
   int          held_m;
   logic [W-1:0] exp_q [$];
   logic        exp_ready_m, exp_dv_m;
   int          pres_m;

   dcache_req_tracker #(.NUM_ENTRIES(N), .TAG_W(TAG_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_cmd_i(req_cmd), .req_size_i(req_size), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_rd_i(req_rd), .kill_i(kill),
      .dmem_req_valid_o(dmem_valid), .dmem_req_ready_i(dmem_ready),
      .dmem_req_cmd_o(dmem_cmd), .dmem_req_addr_o(dmem_addr),
      .dmem_op_type_o(dmem_op), .dmem_req_data_o(dmem_data), .dmem_req_tag_o(dmem_tag),
      .dmem_resp_valid_i(resp_valid_in), .dmem_resp_nack_i(resp_nack),
      .dmem_resp_tag_i(resp_tag), .dmem_resp_data_i(resp_data_in),
      .resp_valid_o(resp_valid), .resp_rd_o(resp_rd), .resp_data_o(resp_data),
      .outstanding_o(outstanding)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) st_m[i] = S_FREE;
      age_q.delete();
      exp_q.delete();
      held_m = -1;
   endtask

   task automatic age_remove(input int t);
      for (int k = 0; k < age_q.size(); k++) begin
         if (age_q[k] == t) begin
            age_q.delete(k);
            break;
         end
      end
   endtask

   task automatic model_check();
      int n_busy;
      logic any_free;
      logic [W-1:0] e;
      any_free = 1'b0;
      n_busy   = 0;
      for (int i = 0; i < N; i++) begin
         if (st_m[i] == S_FREE) any_free = 1'b1;
         else n_busy++;
      end
      exp_ready_m = any_free && !kill;
      exp_dv_m    = 1'b0;
      pres_m      = -1;
      if (held_m >= 0) begin
         exp_dv_m = 1'b1;
         pres_m   = held_m;
      end else begin
         foreach (age_q[k]) begin
            if (!exp_dv_m && st_m[age_q[k]] == S_PEND) begin
               exp_dv_m = 1'b1;
               pres_m   = age_q[k];
            end
         end
      end
      check("req_ready", req_ready, exp_ready_m);
      check("dmem_valid", dmem_valid, exp_dv_m);
      if (exp_dv_m) begin
         check("dmem_tag", dmem_tag, pres_m);
         check("dmem_addr", dmem_addr, addr_m[pres_m]);
         check("dmem_cmd", dmem_cmd, cmd_m[pres_m]);
         check("dmem_op", dmem_op, size_m[pres_m]);
         check("dmem_data", dmem_data, data_m[pres_m]);
      end
      check("outstanding", outstanding, n_busy);
      check("resp_valid", resp_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("resp_rd", resp_rd, e[68:64]);
         check("resp_data", resp_data, e[63:0]);
      end
   endtask

   task automatic model_update();
      int st_n [N];
      int a;
      int t;
      st_n = st_m;
      if (req_valid && exp_ready_m) begin
         a = -1;
         for (int i = N - 1; i >= 0; i--) if (st_m[i] == S_FREE) a = i;
         st_n[a]   = S_PEND;
         rd_m[a]   = req_rd;
         cmd_m[a]  = req_cmd;
         size_m[a] = req_size;
         addr_m[a] = req_addr;
         data_m[a] = req_data;
         age_q.push_back(a);
      end
      if (exp_dv_m && dmem_ready) st_n[pres_m] = S_ISS;
      if (resp_valid_in && int'(resp_tag) < N) begin
         t = int'(resp_tag);
         if (st_m[t] == S_ISS) begin
            if (resp_nack) st_n[t] = S_PEND;
            else begin
               st_n[t] = S_FREE;
               age_remove(t);
               if (!kill) exp_q.push_back({rd_m[t], resp_data_in});
            end
         end else if (st_m[t] == S_KIL) begin
            st_n[t] = S_FREE;
            age_remove(t);
         end
      end
      if (kill) begin
         for (int i = 0; i < N; i++) begin
            if (st_n[i] == S_PEND) begin
               st_n[i] = S_FREE;
               age_remove(i);
            end else if (st_n[i] == S_ISS) begin
               st_n[i] = S_KIL;
            end
         end
      end
      held_m = (exp_dv_m && !dmem_ready && !kill) ? pres_m : -1;
      st_m   = st_n;
   endtask

   // One clock: inputs are already set at the falling edge.
   task automatic tick();
      #1;
      model_check();
      model_update();
      @(negedge clk);
   endtask

   task automatic set_idle();
      req_valid     = 1'b0;
      kill          = 1'b0;
      resp_valid_in = 1'b0;
      resp_nack     = 1'b0;
      resp_tag      = '0;
   endtask

   task automatic send_req(input logic [4:0] rd);
      req_valid = 1'b1;
      req_rd    = rd;
      req_cmd   = ($urandom_range(0, 1) == 0) ? M_XRD : M_XWR;
      req_size  = 4'($urandom_range(0, 3));
      req_addr  = 40'({$urandom(), $urandom()});
      req_data  = {$urandom(), $urandom()};
   endtask

   task automatic send_resp(input int tag, input logic nack);
      resp_valid_in = 1'b1;
      resp_nack     = nack;
      resp_tag      = TAG_W'(tag);
      resp_data_in  = {$urandom(), $urandom()};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin : main
      logic [39:0] st_addr;
      bus_simd_t   st_data;
      int          cand [$];
      req_cmd = M_XRD; req_size = '0; req_addr = '0; req_data = '0; req_rd = '0;
      resp_data_in = '0;
      dmem_ready = 1'b1;
      do_reset();
      check("rst_resp_rd", resp_rd, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_dmem_addr", dmem_addr, 0);
      check("rst_dmem_data", dmem_data, 0);
      check("rst_dmem_tag", dmem_tag, 0);

      // single load
      set_idle(); send_req(5'd5); tick();
      set_idle();
      check("single_valid", dmem_valid, 1);
      check("single_tag", dmem_tag, 0);
      tick(); tick(); tick();
      send_resp(0, 1'b0); tick();
      set_idle();
      check("single_resp_valid", resp_valid, 1);
      check("single_resp_rd", resp_rd, 5);
      tick();

      // full, then out-of-order drain 2,0,1,3
      for (int i = 0; i < N; i++) begin
         set_idle(); send_req(5'(i + 1)); tick();
      end
      set_idle();
      check("full_ready", req_ready, 0);
      check("full_outstanding", outstanding, 4);
      tick(); tick();
      send_resp(2, 1'b0); tick();
      set_idle();
      check("full_ready_after", req_ready, 1);
      check("ooo_rd_t2", resp_rd, 3);
      send_resp(0, 1'b0); tick();
      set_idle();
      check("ooo_rd_t0", resp_rd, 1);
      send_resp(1, 1'b0); tick();
      set_idle();
      check("ooo_rd_t1", resp_rd, 2);
      send_resp(3, 1'b0); tick();
      set_idle(); tick();

      // nack replay ahead of a younger pending entry
      send_req(5'd7); tick();
      set_idle(); send_req(5'd8); tick();
      set_idle(); tick();
      send_req(5'd9); send_resp(1, 1'b1); tick();
      set_idle();
      check("nack_replay_tag", dmem_tag, 1);
      tick();
      check("nack_younger_tag", dmem_tag, 2);
      tick();
      for (int t = 0; t < 3; t++) begin
         send_resp(t, 1'b0); tick(); set_idle();
      end
      tick();

      // kill with two issued and one stalled pending
      send_req(5'd11); tick();
      set_idle(); send_req(5'd12); tick();
      set_idle(); send_req(5'd13); tick();
      set_idle(); dmem_ready = 1'b0; kill = 1'b1; tick();
      set_idle(); dmem_ready = 1'b1;
      check("kill_outstanding", outstanding, 2);
      check("kill_no_issue", dmem_valid, 0);
      send_resp(0, 1'b0); tick();
      set_idle(); send_resp(1, 1'b0); tick();
      set_idle();
      check("kill_no_resp", resp_valid, 0);
      tick();
      check("kill_drained", outstanding, 0);

      // stall: outputs must hold while the dcache is not ready
      dmem_ready = 1'b0;
      send_req(5'd20); st_addr = req_addr; st_data = req_data; tick();
      set_idle();
      for (int c = 0; c < 3; c++) begin
         check("stall_tag", dmem_tag, 0);
         check("stall_addr", dmem_addr, st_addr);
         check("stall_data", dmem_data, st_data);
         tick();
      end
      dmem_ready = 1'b1; tick();
      send_resp(0, 1'b0); tick();
      set_idle(); tick();

      // reset with requests in flight; late responses must be dropped
      send_req(5'd21); tick();
      set_idle(); send_req(5'd22); tick();
      set_idle(); tick();
      do_reset();
      send_resp(0, 1'b0); tick();
      set_idle(); send_resp(1, 1'b0); tick();
      set_idle();
      check("reset_drop_resp", resp_valid, 0);
      tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         set_idle();
         dmem_ready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 50) send_req(5'($urandom_range(0, 31)));
         cand.delete();
         for (int i = 0; i < N; i++) if (st_m[i] == S_ISS || st_m[i] == S_KIL) cand.push_back(i);
         if ($urandom_range(0, 99) < 5) send_resp($urandom_range(0, 255), 1'($urandom_range(0, 1)));
         else if (cand.size() > 0 && $urandom_range(0, 99) < 40)
            send_resp(cand[$urandom_range(0, cand.size() - 1)], $urandom_range(0, 99) < 25);
         kill = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 999) < 5) do_reset();
         else tick();
      end
      set_idle(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_req_tracker.md
DCACHE_REQ_TRACKER -- requirements
Module: dcache_req_tracker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, number of outstanding requests (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 8, dcache tag width; the entry index is zero-extended into the tag.
REQ-003 SHALL have ports `clk_i` (in, 1, sole clock) and `rst_i` (in, 1, synchronous active-high reset), listed first.
REQ-004 SHALL have CPU request ports:
- `req_valid_i` (in, 1) and `req_ready_o` (out, 1): request handshake.
- `req_cmd_i` (in, 5) and `req_size_i` (in, 4): command and size.
- `req_addr_i` (in, 40): address.
- `req_data_i` (in, bus_simd_t): store data.
- `req_rd_i` (in, 5): destination register.
REQ-005 SHALL have port `kill_i` (in, 1), which flushes every request not yet retired.
REQ-006 SHALL have dcache request ports:
- `dmem_req_valid_o` (out, 1) and `dmem_req_ready_i` (in, 1): issue handshake.
- `dmem_req_cmd_o` (out, 5), `dmem_req_addr_o` (out, 40), `dmem_op_type_o` (out, 4), `dmem_req_data_o` (out, bus_simd_t).
- `dmem_req_tag_o` (out, TAG_W).
REQ-007 SHALL have dcache response ports: `dmem_resp_valid_i` (in, 1), `dmem_resp_nack_i` (in, 1), `dmem_resp_tag_i` (in, TAG_W), `dmem_resp_data_i` (in, bus_simd_t).
REQ-008 SHALL have CPU response ports: `resp_valid_o` (out, 1), `resp_rd_o` (out, 5), `resp_data_o` (out, bus_simd_t).
REQ-009 SHALL have port `outstanding_o` (out, $clog2(NUM_ENTRIES)+1), the count of non-FREE entries.

Function
REQ-010 SHALL keep exactly one state per entry: FREE, PENDING (awaiting issue), ISSUED (awaiting response) or KILLED (issued then flushed, awaiting response).
REQ-011 SHALL drive `req_ready_o` = (any FREE entry) && !`kill_i`.
REQ-012 SHALL, on `req_valid_i && req_ready_o`, write the request into the lowest-index FREE entry and set it to PENDING, with the entry's age rank set to youngest.
REQ-013 SHALL drive `dmem_req_valid_o` when any entry is PENDING, presenting the oldest PENDING entry; the tag is the entry index.
REQ-014 SHALL hold the presented entry and all `dmem_req_*` outputs stable while `dmem_req_valid_o && !dmem_req_ready_i`.
REQ-015 SHALL move the presented entry PENDING->ISSUED on `dmem_req_valid_o && dmem_req_ready_i`.
REQ-016 SHALL limit latency: a request accepted in cycle N appears on `dmem_req_valid_o` no earlier than cycle N+1.
REQ-017 SHALL, on `dmem_resp_valid_i && dmem_resp_nack_i` for an ISSUED tag, return that entry to PENDING (replay) with its age unchanged.
REQ-018 SHALL, on `dmem_resp_valid_i && dmem_resp_nack_i` for a KILLED tag, move the entry to FREE.
REQ-019 SHALL, on `dmem_resp_valid_i && !dmem_resp_nack_i` for an ISSUED tag, free the entry and assert `resp_valid_o` for one cycle, next cycle, carrying the stored rd and the registered response data.
REQ-020 SHALL, on a non-nack response for a KILLED tag, free the entry without asserting `resp_valid_o`.
REQ-021 SHALL ignore responses whose tag is FREE, PENDING or >= NUM_ENTRIES.
REQ-022 SHALL, on `kill_i`, next cycle: PENDING->FREE, ISSUED->KILLED, and suppress a `resp_valid_o` due from a response in the same cycle.
REQ-023 SHALL, when a handshake coincides with `kill_i`, apply the handshake first and the kill second: the entry ends KILLED.
REQ-024 SHALL make an entry freed in cycle N allocatable no earlier than cycle N+1; allocation, issue and response SHALL each occur in the same cycle on distinct entries.
REQ-025 SHALL deassert `req_ready_o` when all entries are non-FREE (full), with no loss or overwrite of entries.

Reset
REQ-026 SHALL, while `rst_i` is high at a clock edge, set all entries FREE and drive `req_ready_o`=1, `dmem_req_valid_o`=0, `resp_valid_o`=0, `outstanding_o`=0, and all data outputs to 0.
REQ-027 SHALL discard in-flight requests on reset mid-operation, and SHALL drop responses arriving after reset (their tags are FREE).

Structure
REQ-028 SHALL place the entry-state enum, the entry record type and the memory command constants in drac_pkg.
REQ-029 SHALL use one sub-module, dcache_req_age_matrix, which tracks allocation order and selects the oldest PENDING entry.

Verification
REQ-030 SHALL cover single load: ready=1, accept rd=5 at cycle 0 -> tag 0 issued at cycle 1; response at cycle 4 -> resp_valid_o at cycle 5 with rd=5.
REQ-031 SHALL cover full: NUM_ENTRIES=4, four requests and no responses -> req_ready_o=0 and outstanding_o=4; one response -> ready=1 the next cycle.
REQ-032 SHALL cover nack replay: tag 1 nacked -> reissued with tag 1 before a younger PENDING tag 2.
REQ-033 SHALL cover kill: two ISSUED and one PENDING entry, then kill_i -> the PENDING entry is freed; later responses for the ISSUED tags produce no resp_valid_o; outstanding_o reaches 0.
REQ-034 SHALL cover out-of-order: responses for tags 2, 0, 1 -> resp_rd_o values match the stored rd of each tag, in response order.
REQ-035 SHALL cover stall: dmem_req_ready_i=0 for 3 cycles -> tag, addr and data outputs stay constant.
